// File: rtl/riscv_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : riscv_ctrl_pkg
//  Description : Shared encodings for the multi-cycle RV32I main controller:
//                opcodes, branch func3 codes, ALUOp codes, datapath select
//                encodings and the controller state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package riscv_ctrl_pkg;

  localparam int STATE_W = 4;

  // Supported major opcodes (instr[6:0])
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  // Branch func3 codes
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_BLT = 3'b100;
  localparam logic [2:0] F3_BGE = 3'b101;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_ITYPE = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    SRCA_PC    = 2'b00,
    SRCA_OLDPC = 2'b01,
    SRCA_RS1   = 2'b10
  } src_a_e;

  typedef enum logic [1:0] {
    SRCB_RS2  = 2'b00,
    SRCB_IMM  = 2'b01,
    SRCB_FOUR = 2'b10
  } src_b_e;

  typedef enum logic [1:0] {
    RES_ALUOUT = 2'b00,
    RES_MEM    = 2'b01,
    RES_ALU    = 2'b10,
    RES_IMM    = 2'b11
  } result_e;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } imm_e;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEM_ADR = 4'd2,
    S_MEM_RD  = 4'd3,
    S_MEM_WB  = 4'd4,
    S_MEM_WR  = 4'd5,
    S_EX_R    = 4'd6,
    S_EX_I    = 4'd7,
    S_ALU_WB  = 4'd8,
    S_BRANCH  = 4'd9,
    S_JAL     = 4'd10,
    S_JALR    = 4'd11,
    S_JAL_WB  = 4'd12,
    S_LUI     = 4'd13
  } state_e;

endpackage
`default_nettype wire

// File: rtl/multicycle_main_controller_if.sv
`default_nettype none
// ============================================================================
//  Interface   : multicycle_main_controller_if
//  Description : Controller <-> datapath bundle. master = controller side,
//                slave = datapath side.
//  Ports       : opcode[6:0], func3[2:0], zero, lt, mem_ready (datapath->ctrl)
//                pc_write, adr_src, ir_write, mem_write, reg_write,
//                alu_src_a[1:0], alu_src_b[1:0], result_src[1:0],
//                imm_src[2:0], alu_op[1:0], retire, illegal (ctrl->datapath)
//  Revision    : 1.0 - initial release
// ============================================================================
interface multicycle_main_controller_if;
  logic [6:0] opcode;
  logic [2:0] func3;
  logic       zero;
  logic       lt;
  logic       mem_ready;

  logic       pc_write;
  logic       adr_src;
  logic       ir_write;
  logic       mem_write;
  logic       reg_write;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] result_src;
  logic [2:0] imm_src;
  logic [1:0] alu_op;
  logic       retire;
  logic       illegal;

  modport master (
    input  opcode, func3, zero, lt, mem_ready,
    output pc_write, adr_src, ir_write, mem_write, reg_write,
           alu_src_a, alu_src_b, result_src, imm_src, alu_op,
           retire, illegal
  );

  modport slave (
    output opcode, func3, zero, lt, mem_ready,
    input  pc_write, adr_src, ir_write, mem_write, reg_write,
           alu_src_a, alu_src_b, result_src, imm_src, alu_op,
           retire, illegal
  );
endinterface
`default_nettype wire

// File: rtl/branch_cond_unit.sv
`default_nettype none
// ============================================================================
//  Module      : branch_cond_unit
//  Description : Combinational branch-taken decision from func3 and the
//                datapath zero / signed-less-than flags.
//  Ports       : func3[2:0] in, zero in, lt in, take out
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_cond_unit
  import riscv_ctrl_pkg::*;
(
  input  logic [2:0] func3,
  input  logic       zero,
  input  logic       lt,
  output logic       take
);

  always_comb begin
    take = 1'b0;
    case (func3)
      F3_BEQ:  take = zero;
      F3_BNE:  take = ~zero;
      F3_BLT:  take = lt;
      F3_BGE:  take = ~lt;
      default: take = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_main_controller.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_main_controller
//  Description : Main Moore FSM of the multi-cycle RV32I core. Sequences
//                fetch / decode / execute / memory / writeback over the
//                shared ALU and memory and drives the datapath selects,
//                enables and the 2-bit ALUOp.
//  Ports       : clk  in  - rising-edge clock
//                rst  in  - synchronous active-high reset
//                bus  multicycle_main_controller_if.master
//  Config      : MEM_READY_HS_EN - when defined, FETCH / MEM_RD / MEM_WR wait
//                for bus.mem_ready; otherwise memory is single-cycle and
//                mem_ready is ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_main_controller
  import riscv_ctrl_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  multicycle_main_controller_if.master bus
);

  state_e  r_state;
  state_e  w_next_state;
  logic    w_take;
  logic    w_mem_go;

  logic    w_pc_write;
  logic    w_adr_src;
  logic    w_ir_write;
  logic    w_mem_write;
  logic    w_reg_write;
  src_a_e  w_alu_src_a;
  src_b_e  w_alu_src_b;
  result_e w_result_src;
  imm_e    w_imm_src;
  alu_op_e w_alu_op;
  logic    w_retire;
  logic    w_illegal;

  branch_cond_unit u_branch_cond (
    .func3 (bus.func3),
    .zero  (bus.zero),
    .lt    (bus.lt),
    .take  (w_take)
  );

`ifdef MEM_READY_HS_EN
  assign w_mem_go = bus.mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = bus.mem_ready;
  assign w_mem_go         = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = S_FETCH;
    w_pc_write   = 1'b0;
    w_adr_src    = 1'b0;
    w_ir_write   = 1'b0;
    w_mem_write  = 1'b0;
    w_reg_write  = 1'b0;
    w_alu_src_a  = SRCA_PC;
    w_alu_src_b  = SRCB_RS2;
    w_result_src = RES_ALUOUT;
    w_imm_src    = IMM_I;
    w_alu_op     = ALUOP_ADD;
    w_retire     = 1'b0;
    w_illegal    = 1'b0;

    case (r_state)
      S_FETCH: begin
        // PC <= PC + 4 and IR/oldPC capture only on the cycle memory answers
        w_adr_src    = 1'b0;
        w_ir_write   = w_mem_go;
        w_alu_src_a  = SRCA_PC;
        w_alu_src_b  = SRCB_FOUR;
        w_result_src = RES_ALU;
        w_pc_write   = w_mem_go;
        w_next_state = w_mem_go ? S_DECODE : S_FETCH;
      end

      S_DECODE: begin
        // Speculative target oldPC+imm into ALUOut; JAL needs the J immediate
        w_alu_src_a = SRCA_OLDPC;
        w_alu_src_b = SRCB_IMM;
        w_imm_src   = (bus.opcode == OP_JAL) ? IMM_J : IMM_B;
        w_alu_op    = ALUOP_ADD;
        case (bus.opcode)
          OP_R:      w_next_state = S_EX_R;
          OP_I:      w_next_state = S_EX_I;
          OP_LOAD,
          OP_STORE:  w_next_state = S_MEM_ADR;
          OP_BRANCH: w_next_state = S_BRANCH;
          OP_JAL:    w_next_state = S_JAL;
          OP_JALR:   w_next_state = S_JALR;
          OP_LUI:    w_next_state = S_LUI;
          default: begin
            w_illegal    = 1'b1;
            w_next_state = S_FETCH;
          end
        endcase
      end

      S_EX_R: begin
        w_alu_src_a  = SRCA_RS1;
        w_alu_src_b  = SRCB_RS2;
        w_alu_op     = ALUOP_RTYPE;
        w_next_state = S_ALU_WB;
      end

      S_EX_I: begin
        w_alu_src_a  = SRCA_RS1;
        w_alu_src_b  = SRCB_IMM;
        w_imm_src    = IMM_I;
        w_alu_op     = ALUOP_ITYPE;
        w_next_state = S_ALU_WB;
      end

      S_ALU_WB: begin
        w_result_src = RES_ALUOUT;
        w_reg_write  = 1'b1;
        w_retire     = 1'b1;
        w_next_state = S_FETCH;
      end

      S_MEM_ADR: begin
        w_alu_src_a  = SRCA_RS1;
        w_alu_src_b  = SRCB_IMM;
        w_alu_op     = ALUOP_ADD;
        w_imm_src    = (bus.opcode == OP_STORE) ? IMM_S : IMM_I;
        w_next_state = (bus.opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
      end

      S_MEM_RD: begin
        w_adr_src    = 1'b1;
        w_next_state = w_mem_go ? S_MEM_WB : S_MEM_RD;
      end

      S_MEM_WB: begin
        w_result_src = RES_MEM;
        w_reg_write  = 1'b1;
        w_retire     = 1'b1;
        w_next_state = S_FETCH;
      end

      S_MEM_WR: begin
        w_adr_src    = 1'b1;
        w_mem_write  = w_mem_go;
        w_retire     = w_mem_go;
        w_next_state = w_mem_go ? S_FETCH : S_MEM_WR;
      end

      S_BRANCH: begin
        // PC <= ALUOut (target computed in DECODE) only when taken
        w_alu_src_a  = SRCA_RS1;
        w_alu_src_b  = SRCB_RS2;
        w_alu_op     = ALUOP_SUB;
        w_result_src = RES_ALUOUT;
        w_pc_write   = w_take;
        w_retire     = 1'b1;
        w_next_state = S_FETCH;
      end

      S_JAL: begin
        // PC <= ALUOut (oldPC+immJ) while the ALU forms oldPC+4 as link value
        w_alu_src_a  = SRCA_OLDPC;
        w_alu_src_b  = SRCB_FOUR;
        w_alu_op     = ALUOP_ADD;
        w_imm_src    = IMM_J;
        w_result_src = RES_ALUOUT;
        w_pc_write   = 1'b1;
        w_next_state = S_ALU_WB;
      end

      S_JALR: begin
        w_alu_src_a  = SRCA_RS1;
        w_alu_src_b  = SRCB_IMM;
        w_imm_src    = IMM_I;
        w_alu_op     = ALUOP_ADD;
        w_result_src = RES_ALU;
        w_pc_write   = 1'b1;
        w_next_state = S_JAL_WB;
      end

      S_JAL_WB: begin
        w_alu_src_a  = SRCA_OLDPC;
        w_alu_src_b  = SRCB_FOUR;
        w_result_src = RES_ALU;
        w_reg_write  = 1'b1;
        w_retire     = 1'b1;
        w_next_state = S_FETCH;
      end

      S_LUI: begin
        w_imm_src    = IMM_U;
        w_result_src = RES_IMM;
        w_reg_write  = 1'b1;
        w_retire     = 1'b1;
        w_next_state = S_FETCH;
      end

      default: w_next_state = S_FETCH;
    endcase
  end

  // Outputs are forced quiet while reset is held so an aborted instruction
  // cannot write anything in the reset cycle.
  assign bus.pc_write   = rst ? 1'b0   : w_pc_write;
  assign bus.adr_src    = rst ? 1'b0   : w_adr_src;
  assign bus.ir_write   = rst ? 1'b0   : w_ir_write;
  assign bus.mem_write  = rst ? 1'b0   : w_mem_write;
  assign bus.reg_write  = rst ? 1'b0   : w_reg_write;
  assign bus.alu_src_a  = rst ? 2'b00  : w_alu_src_a;
  assign bus.alu_src_b  = rst ? 2'b00  : w_alu_src_b;
  assign bus.result_src = rst ? 2'b00  : w_result_src;
  assign bus.imm_src    = rst ? 3'b000 : w_imm_src;
  assign bus.alu_op     = rst ? 2'b00  : w_alu_op;
  assign bus.retire     = rst ? 1'b0   : w_retire;
  assign bus.illegal    = rst ? 1'b0   : w_illegal;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_main_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_main_controller
//  Description : Self-checking bench for multicycle_main_controller. Each
//                issued instruction pushes a transaction-level expectation
//                (cycle count, strobe counts, key selects) into a queue; a
//                monitor closes a transaction on retire/illegal and compares.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_main_controller;

  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] OPC_I   = 7'b0010011;
  localparam logic [6:0] OPC_LW  = 7'b0000011;
  localparam logic [6:0] OPC_SW  = 7'b0100011;
  localparam logic [6:0] OPC_BR  = 7'b1100011;
  localparam logic [6:0] OPC_JAL = 7'b1101111;
  localparam logic [6:0] OPC_JLR = 7'b1100111;
  localparam logic [6:0] OPC_LUI = 7'b0110111;

  typedef struct {
    int illegal;
    int retire;
    int cycles;
    int n_reg;
    int n_mem;
    int n_pc;
    int n_ir;
    int n_adr;
    int dec_imm;
    int care_wb;
    int wb_res;
    int care_ex;
    int ex_a;
    int ex_b;
    int ex_op;
    int care_imm3;
    int ex_imm;
  } exp_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_err;
  exp_t exp_q[$];

  multicycle_main_controller_if bus ();

  multicycle_main_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Transaction-level reference: what one instruction should look like as a whole.
  function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3,
                                 input logic z, input logic l, input int stall);
    exp_t e;
    int   take;
    e = '{default: 0};
    e.retire  = 1;
    e.n_ir    = 1;
    e.n_pc    = 1;
    e.dec_imm = 2;
    case (op)
      OPC_R: begin
        e.cycles = 4; e.n_reg = 1; e.care_wb = 1; e.wb_res = 0;
        e.care_ex = 1; e.ex_a = 2; e.ex_b = 0; e.ex_op = 2;
      end
      OPC_I: begin
        e.cycles = 4; e.n_reg = 1; e.care_wb = 1; e.wb_res = 0;
        e.care_ex = 1; e.ex_a = 2; e.ex_b = 1; e.ex_op = 3;
        e.care_imm3 = 1; e.ex_imm = 0;
      end
      OPC_LW: begin
        e.cycles = 5; e.n_reg = 1; e.n_adr = 1; e.care_wb = 1; e.wb_res = 1;
        e.care_ex = 1; e.ex_a = 2; e.ex_b = 1; e.ex_op = 0;
        e.care_imm3 = 1; e.ex_imm = 0;
      end
      OPC_SW: begin
        e.cycles = 4; e.n_mem = 1; e.n_adr = 1;
        e.care_ex = 1; e.ex_a = 2; e.ex_b = 1; e.ex_op = 0;
        e.care_imm3 = 1; e.ex_imm = 1;
      end
      OPC_BR: begin
        case (f3)
          3'b000:  take = z ? 1 : 0;
          3'b001:  take = z ? 0 : 1;
          3'b100:  take = l ? 1 : 0;
          3'b101:  take = l ? 0 : 1;
          default: take = 0;
        endcase
        e.cycles = 3; e.n_pc = 1 + take;
        e.care_ex = 1; e.ex_a = 2; e.ex_b = 0; e.ex_op = 1;
      end
      OPC_JAL: begin
        e.cycles = 4; e.n_reg = 1; e.n_pc = 2; e.dec_imm = 3;
        e.care_wb = 1; e.wb_res = 0;
        e.care_ex = 1; e.ex_a = 1; e.ex_b = 2; e.ex_op = 0;
        e.care_imm3 = 1; e.ex_imm = 3;
      end
      OPC_JLR: begin
        e.cycles = 4; e.n_reg = 1; e.n_pc = 2; e.care_wb = 1; e.wb_res = 2;
        e.care_ex = 1; e.ex_a = 2; e.ex_b = 1; e.ex_op = 0;
        e.care_imm3 = 1; e.ex_imm = 0;
      end
      OPC_LUI: begin
        e.cycles = 3; e.n_reg = 1; e.care_wb = 1; e.wb_res = 3;
        e.care_imm3 = 1; e.ex_imm = 4;
      end
      default: begin
        e.cycles = 2; e.illegal = 1; e.retire = 0;
      end
    endcase
    e.cycles += stall;
    return e;
  endfunction

  // ---------------- monitor ----------------
  int         m_cyc, m_reg, m_mem, m_pc, m_ir, m_adr, m_ret, m_ill, m_wb;
  logic [1:0] rec_a   [8];
  logic [1:0] rec_b   [8];
  logic [1:0] rec_op  [8];
  logic [1:0] rec_res [8];
  logic [2:0] rec_imm [8];
  logic       rec_adr [8];

  task automatic clear_acc();
    m_cyc = 0; m_reg = 0; m_mem = 0; m_pc = 0; m_ir = 0;
    m_adr = 0; m_ret = 0; m_ill = 0; m_wb = 0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      check("reset_outputs",
            {14'd0, bus.pc_write, bus.adr_src, bus.ir_write, bus.mem_write, bus.reg_write,
             bus.alu_src_a, bus.alu_src_b, bus.result_src, bus.imm_src, bus.alu_op,
             bus.retire, bus.illegal}, 32'd0);
      clear_acc();
    end else begin
      if (m_cyc < 8) begin
        rec_a[m_cyc]   = bus.alu_src_a;
        rec_b[m_cyc]   = bus.alu_src_b;
        rec_op[m_cyc]  = bus.alu_op;
        rec_res[m_cyc] = bus.result_src;
        rec_imm[m_cyc] = bus.imm_src;
        rec_adr[m_cyc] = bus.adr_src;
      end
      m_reg += int'(bus.reg_write);
      m_mem += int'(bus.mem_write);
      m_pc  += int'(bus.pc_write);
      m_ir  += int'(bus.ir_write);
      m_adr += int'(bus.adr_src);
      m_ret += int'(bus.retire);
      m_ill += int'(bus.illegal);
      if (bus.reg_write) m_wb = int'(bus.result_src);
      m_cyc++;
      if (bus.retire || bus.illegal) begin
        if (exp_q.size() == 0) begin
          check("unexpected_end", 32'(m_cyc), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("cycles",      32'(m_cyc), 32'(e.cycles));
          check("illegal_cnt", 32'(m_ill), 32'(e.illegal));
          check("retire_cnt",  32'(m_ret), 32'(e.retire));
          check("reg_write",   32'(m_reg), 32'(e.n_reg));
          check("mem_write",   32'(m_mem), 32'(e.n_mem));
          check("pc_write",    32'(m_pc),  32'(e.n_pc));
          check("ir_write",    32'(m_ir),  32'(e.n_ir));
          check("adr_src",     32'(m_adr), 32'(e.n_adr));
          check("fetch_sel", {25'd0, rec_adr[0], rec_a[0], rec_b[0], rec_res[0]},
                {25'd0, 1'b0, 2'b00, 2'b10, 2'b10});
          check("decode_sel", {23'd0, rec_a[1], rec_b[1], rec_op[1], rec_imm[1]},
                {23'd0, 2'b01, 2'b01, 2'b00, 3'(e.dec_imm)});
          if (e.care_wb != 0)
            check("wb_result_src", 32'(m_wb), 32'(e.wb_res));
          if (e.care_ex != 0)
            check("ex_sel", {26'd0, rec_a[2], rec_b[2], rec_op[2]},
                  {26'd0, 2'(e.ex_a), 2'(e.ex_b), 2'(e.ex_op)});
          if (e.care_imm3 != 0)
            check("ex_imm_src", {29'd0, rec_imm[2]}, 32'(e.ex_imm));
        end
        clear_acc();
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(input logic [6:0] op, input logic [2:0] f3,
                       input logic z, input logic l, input int stall);
    bit done;
    bus.opcode = op;
    bus.func3  = f3;
    bus.zero   = z;
    bus.lt     = l;
    exp_q.push_back(model(op, f3, z, l, stall));
`ifdef MEM_READY_HS_EN
    if (stall > 0) begin
      bus.mem_ready = 1'b0;
      repeat (stall) @(posedge clk);
      #1;
    end
    bus.mem_ready = 1'b1;
`else
    bus.mem_ready = 1'($urandom_range(0, 1));
`endif
    done = 1'b0;
    for (int n = 0; n < 20 + stall; n++) begin
      @(negedge clk);
      if (bus.retire || bus.illegal) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      n_checks++;
      n_err++;
      $display("FAIL timeout: opcode=%b no retire/illegal within %0d cycles", op, 20 + stall);
      rst = 1'b1;
      @(posedge clk);
      #1;
      exp_q.delete();
      rst = 1'b0;
    end else begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [6:0] rand_opcode();
    logic [6:0] ops [12];
    ops = '{OPC_R, OPC_I, OPC_LW, OPC_SW, OPC_BR, OPC_JAL, OPC_JLR, OPC_LUI,
            7'b1111111, 7'b0000000, 7'b0010111, 7'b1110011};
    return ops[$urandom_range(0, 11)];
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks      = 0;
    n_err         = 0;
    rst           = 1'b1;
    bus.opcode    = 7'd0;
    bus.func3     = 3'd0;
    bus.zero      = 1'b0;
    bus.lt        = 1'b0;
    bus.mem_ready = 1'b1;
    clear_acc();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed cases
    issue(OPC_R,  3'b000, 1'b0, 1'b0, 0);
    issue(OPC_LW, 3'b010, 1'b0, 1'b0, 0);
    issue(OPC_SW, 3'b010, 1'b0, 1'b0, 0);
    issue(OPC_BR, 3'b000, 1'b1, 1'b0, 0);
    issue(OPC_BR, 3'b000, 1'b0, 1'b0, 0);
    issue(OPC_BR, 3'b100, 1'b0, 1'b1, 0);
    issue(OPC_BR, 3'b101, 1'b0, 1'b1, 0);
    issue(OPC_BR, 3'b001, 1'b0, 1'b0, 0);
    issue(7'b1111111, 3'b000, 1'b0, 1'b0, 0);
    issue(OPC_JAL, 3'b000, 1'b0, 1'b0, 0);
    issue(OPC_JLR, 3'b000, 1'b0, 1'b0, 0);
    issue(OPC_LUI, 3'b000, 1'b0, 1'b0, 0);
    issue(OPC_I,   3'b000, 1'b0, 1'b0, 0);

    // Reset while a store sits in its write cycle: no expectation pushed,
    // the monitor requires quiet outputs during reset and the next
    // instruction must start cleanly from fetch.
    bus.opcode    = OPC_SW;
    bus.mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    issue(OPC_R, 3'b000, 1'b0, 1'b0, 0);

`ifdef MEM_READY_HS_EN
    issue(OPC_R,  3'b000, 1'b0, 1'b0, 3);
    issue(OPC_LW, 3'b010, 1'b0, 1'b0, 2);
`endif

    // Randomized instruction stream
    for (int i = 0; i < 120; i++) begin
      issue(rand_opcode(), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 0);
    end

    repeat (2) @(posedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
